// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// The sequencer only needs to remember whether a wrong-path fetch is still outstanding.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } hz_state_e;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: +1 per cycle with inc_i, sticks at all-ones, cleared by reset.
// Count is registered, so it is visible one cycle after the counted event.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: turns memory waits, taken branches and load-use hazards
// into per-stage controls (combinational, zero latency) and keeps saturating stall/flush counts.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_busywait_i,
    input  logic                  dmem_busywait_i,
    input  logic                  branch_taken_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    output logic                  pc_stall_o,
    output logic                  pc_sel_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_bubble_o,
    output logic                  ex_mem_stall_o,
    output logic                  mem_wb_stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    hz_state_e state_q;
    hz_state_e state_d;
    logic      load_use;

    // x0 is hardwired zero, so a load targeting it can never feed a dependent.
    assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_d        = state_q;
        pc_stall_o     = 1'b0;
        pc_sel_o       = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_stall_o = 1'b0;

        if (!rst_n) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (dmem_busywait_i) begin
            // Whole pipe frozen; a branch resolved in EX simply waits with it.
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_stall_o = 1'b1;
            if_id_flush_o  = (state_q == ST_DROP);
        end else if (branch_taken_i) begin
            pc_sel_o       = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = imem_busywait_i ? ST_DROP : ST_RUN;
        end else if (state_q == ST_DROP) begin
            // Wrong-path word still in flight: discard it, including on the cycle it returns.
            pc_stall_o     = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (!imem_busywait_i) begin
                state_d = ST_RUN;
            end
        end else if (load_use || imem_busywait_i) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (pc_stall_o),
        .cnt_o (stall_cnt_o)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (if_id_flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule
